cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Parametrised successor to the CPU top-level memory interface.
- Merges NUM_CH independent request channels onto one unified memory port with rdy-style handshakes:
  - channel 0 = instruction fetch, channel 1 = data, extra channels for DMA or a second hart.
- Provides round-robin or fixed-priority arbitration.
- Allows one outstanding transaction at a time.
- Registers all memory-side outputs.

Parameters:
- NUM_CH, 2, number of request channels (2..8).
- AW, 32, address width.
- DW, 32, data width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel request valid.
- ch_wr  input  NUM_CH  per-channel write (1) / read (0).
- ch_addr  input  NUM_CH*AW  packed addresses; channel i at [i*AW +: AW].
- ch_wdata  input  NUM_CH*DW  packed write data; channel i at [i*DW +: DW].
- ch_rdy  output  NUM_CH  per-channel completion strobe, one-hot or zero.
- ch_rdata  output  DW  read data, shared by all channels; valid while ch_rdy is set.
- mem_addr  output  AW  memory address (registered).
- mem_wdata  output  DW  memory write data (registered).
- mem_en  output  1  memory request active.
- mem_wr  output  1  memory write.
- mem_rdata  input  DW  memory read data, valid with mem_rdy.
- mem_rdy  input  1  memory completion, sampled only while mem_en=1.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (synchronous, from any state including mid-BUSY):
  - state = IDLE.
  - mem_en = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - ch_rdy = 0, ch_rdata = 0.
  - rr_ptr = NUM_CH-1, so channel 0 wins the first round-robin arbitration.
  - An in-flight memory access is abandoned; no ch_rdy is issued for it.
- IDLE:
  - If any ch_en is set, choose a winner g:
    - ARB_MODE=0: first set bit scanning from rr_ptr+1 upward, modulo NUM_CH.
    - ARB_MODE=1: lowest set index.
  - On the same edge: latch ch_addr[g] → mem_addr, ch_wdata[g] → mem_wdata, ch_wr[g] → mem_wr; set mem_en = 1; store g; go to BUSY.
  - If no ch_en is set, stay in IDLE with mem_en = 0.
- BUSY:
  - mem_en, mem_addr, mem_wdata and mem_wr are held stable.
  - When mem_rdy = 1:
    - Read: capture mem_rdata → ch_rdata.
    - Write: ch_rdata is unchanged.
    - Clear mem_en and mem_wr; set ch_rdy[g] = 1.
    - If ARB_MODE=0, set rr_ptr = g.
    - Go to RESP.
  - No timeout: BUSY persists until mem_rdy arrives.
- RESP:
  - Lasts exactly one cycle; ch_rdy[g] = 1 and ch_rdata is valid.
  - No arbitration in RESP; next edge clears ch_rdy and returns to IDLE.
- Requester contract:
  - Hold ch_en, ch_wr, ch_addr and ch_wdata stable from assertion until the cycle ch_rdy is seen.
  - Drop ch_en by the edge following the ch_rdy cycle; otherwise the request re-issues as a new transaction.
- Changes to a non-granted channel's inputs during BUSY have no effect.
- Latency:
  - ch_en seen in IDLE at cycle t → mem_en = 1 at t+1.
  - mem_rdy at cycle t+k (k ≥ 1) → ch_rdy at t+k+1.
  - Minimum round trip is 2 cycles; peak throughput is 1 transaction per 3 cycles.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Losers wait, ch_rdy stays low for them, and they are never dropped.
  - Round-robin guarantees each requesting channel is served within NUM_CH transactions.
- Invariants:
  - ch_rdy is at most one-hot.
  - mem_en is never 1 in IDLE or RESP.
  - mem_rdy outside BUSY is ignored.

Test Plan:
- Single read: reset, then ch_en[0]=1, ch_addr[0]=0x100, ch_wr[0]=0; mem_rdy=1 with mem_rdata=0xDEADBEEF one cycle after mem_en → mem_addr=0x100, mem_en high exactly 1 cycle, ch_rdy=2'b01 one cycle later, ch_rdata=0xDEADBEEF.
- Write with stall: ch1 write addr=0x2000, wdata=0x12345678; mem_rdy delayed 4 cycles → mem_en held 4 cycles with stable addr/wdata and mem_wr=1; ch_rdy=2'b10 for one cycle; ch_rdata unchanged.
- Round-robin contention, ARB_MODE=0, NUM_CH=4: all ch_en held continuously, each request held until its ch_rdy, then reasserted → grant order 0,1,2,3,0,… with no channel served twice before the others.
- Fixed priority, ARB_MODE=1: ch0 and ch2 both pending, ch0 reasserts after each completion → ch0 always wins; ch2 served only in an IDLE cycle where ch0 is low.
- Reset mid-BUSY: assert reset while mem_en=1, before mem_rdy → next cycle mem_en=0, all ch_rdy=0; a late mem_rdy pulse produces no ch_rdy; the next arbitration grants channel 0.
- Spurious mem_rdy: pulse mem_rdy in IDLE with no requests → no state change, ch_rdy stays 0, ch_rdata unchanged.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges NUM_CH request channels onto a single memory port.
// One transaction is in flight at a time. Arbitration is round-robin
// (ARB_MODE=0) or fixed priority with the lowest index winning (ARB_MODE=1).
// All memory-side outputs and the per-channel completion strobes are registered.
//
// Handshake: a channel raises ch_en[i] together with stable ch_wr/ch_addr/
// ch_wdata and holds them until it sees ch_rdy[i] for one cycle. The memory
// port raises mem_en with stable mem_addr/mem_wdata/mem_wr and holds them until
// mem_rdy is sampled high; mem_rdy is ignored whenever mem_en is low.
module cpu_mem_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    ch_wr,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_rdy,
    output logic [DW-1:0]        ch_rdata,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_en,
    output logic                 mem_wr,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_rdy,
    output logic [1:0]           dbg_state
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW:0] NUM_CH_W = (CW+1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   win_idx;
    logic            win_valid;
    logic [CW:0]     cand;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_wr;

    assign dbg_state = state;

    // Pick this cycle's winner among requesting channels; only consumed in IDLE.
    // Round-robin scans rr_ptr+1 upward (wrapping); iterating from the far end
    // down lets the nearest requester overwrite the others.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        cand      = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_en[i]) begin
                    win_idx   = CW'(i);
                    win_valid = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                cand = {1'b0, rr_ptr} + (CW+1)'(k);
                if (cand >= NUM_CH_W) begin
                    cand = cand - NUM_CH_W;
                end
                if (ch_en[cand[CW-1:0]]) begin
                    win_idx   = cand[CW-1:0];
                    win_valid = 1'b1;
                end
            end
        end
    end

    // Route the winning channel's request fields toward the memory registers.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_idx == CW'(i)) begin
                sel_addr  = ch_addr[i*AW +: AW];
                sel_wdata = ch_wdata[i*DW +: DW];
                sel_wr    = ch_wr[i];
            end
        end
    end

    // Transaction FSM: IDLE grants and launches, BUSY waits for mem_rdy,
    // RESP presents the one-cycle completion strobe before re-arbitrating.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ch_rdy    <= '0;
            ch_rdata  <= '0;
            rr_ptr    <= CW'(NUM_CH - 1);
            grant_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ch_rdy <= '0;
                    if (win_valid) begin
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_wr    <= sel_wr;
                        mem_en    <= 1'b1;
                        grant_idx <= win_idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        // Writes leave the shared read-data register untouched.
                        if (!mem_wr) begin
                            ch_rdata <= mem_rdata;
                        end
                        mem_en <= 1'b0;
                        mem_wr <= 1'b0;
                        ch_rdy <= NUM_CH'(1) << grant_idx;
                        if (ARB_MODE == 0) begin
                            rr_ptr <= grant_idx;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ch_rdy <= '0;
                    state  <= IDLE;
                end
                default: begin
                    ch_rdy <= '0;
                    mem_en <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Testbench for cpu_mem_arbiter: one round-robin and one fixed-priority
// instance (both 4 channels), a behavioural memory responder per instance,
// and a per-instance queue of expected completions {ch_rdy, ch_rdata}.
module tb_cpu_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = N + DW;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- round-robin instance ----------------
  logic [N-1:0]    rr_ch_en = '0;
  logic [N-1:0]    rr_ch_wr = '0;
  logic [N*AW-1:0] rr_ch_addr = '0;
  logic [N*DW-1:0] rr_ch_wdata = '0;
  logic [N-1:0]    rr_ch_rdy;
  logic [DW-1:0]   rr_ch_rdata;
  logic [AW-1:0]   rr_mem_addr;
  logic [DW-1:0]   rr_mem_wdata;
  logic            rr_mem_en;
  logic            rr_mem_wr;
  logic [DW-1:0]   rr_mem_rdata = '0;
  logic            rr_mem_rdy = 1'b0;
  logic [1:0]      rr_dbg_state;

  cpu_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset(reset),
    .ch_en(rr_ch_en), .ch_wr(rr_ch_wr), .ch_addr(rr_ch_addr), .ch_wdata(rr_ch_wdata),
    .ch_rdy(rr_ch_rdy), .ch_rdata(rr_ch_rdata),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_en(rr_mem_en), .mem_wr(rr_mem_wr),
    .mem_rdata(rr_mem_rdata), .mem_rdy(rr_mem_rdy), .dbg_state(rr_dbg_state)
  );

  // ---------------- fixed-priority instance ----------------
  logic [N-1:0]    fp_ch_en = '0;
  logic [N-1:0]    fp_ch_wr = '0;
  logic [N*AW-1:0] fp_ch_addr = '0;
  logic [N*DW-1:0] fp_ch_wdata = '0;
  logic [N-1:0]    fp_ch_rdy;
  logic [DW-1:0]   fp_ch_rdata;
  logic [AW-1:0]   fp_mem_addr;
  logic [DW-1:0]   fp_mem_wdata;
  logic            fp_mem_en;
  logic            fp_mem_wr;
  logic [DW-1:0]   fp_mem_rdata = '0;
  logic            fp_mem_rdy = 1'b0;
  logic [1:0]      fp_dbg_state;

  cpu_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset(reset),
    .ch_en(fp_ch_en), .ch_wr(fp_ch_wr), .ch_addr(fp_ch_addr), .ch_wdata(fp_ch_wdata),
    .ch_rdy(fp_ch_rdy), .ch_rdata(fp_ch_rdata),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_en(fp_mem_en), .mem_wr(fp_mem_wr),
    .mem_rdata(fp_mem_rdata), .mem_rdy(fp_mem_rdy), .dbg_state(fp_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] rr_exp_q[$];
  logic [EW-1:0] fp_exp_q[$];
  logic [DW-1:0] rr_last = '0;
  logic [DW-1:0] fp_last = '0;
  int total = 0;
  int bad = 0;
  int rr_stall = 0;
  bit rr_resp_on = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
    return (a == 32'h100) ? 32'hDEAD_BEEF : v;
  endfunction

  // ---------------- memory responders ----------------
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (rr_resp_on) begin
        rr_mem_rdy = 1'b0;
        if (rr_mem_en && !reset) begin
          if (cnt >= rr_stall) begin
            rr_mem_rdy = 1'b1;
            rr_mem_rdata = mem_model(rr_mem_addr);
            cnt = 0;
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      fp_mem_rdy = 1'b0;
      if (fp_mem_en && !reset) begin
        fp_mem_rdy = 1'b1;
        fp_mem_rdata = mem_model(fp_mem_addr);
      end
    end
  end

  // ---------------- completion monitors ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clock);
      if (rr_ch_rdy !== '0) begin
        chk("rr_en_low_at_rdy", 64'(rr_mem_en), 64'd0);
        if (rr_exp_q.size() == 0) begin
          chk("rr_unexpected_rdy", 64'(rr_ch_rdy), 64'd0);
        end else begin
          e = rr_exp_q.pop_front();
          chk("rr_rdy", 64'(rr_ch_rdy), 64'(e[EW-1:DW]));
          chk("rr_rdata", 64'(rr_ch_rdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clock);
      if (fp_ch_rdy !== '0) begin
        if (fp_exp_q.size() == 0) begin
          chk("fp_unexpected_rdy", 64'(fp_ch_rdy), 64'd0);
        end else begin
          e = fp_exp_q.pop_front();
          chk("fp_rdy", 64'(fp_ch_rdy), 64'(e[EW-1:DW]));
          chk("fp_rdata", 64'(fp_ch_rdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_ch(input bit fp, input int ch, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit en);
    if (fp) begin
      fp_ch_wr[ch] = wr; fp_ch_addr[ch*AW +: AW] = a; fp_ch_wdata[ch*DW +: DW] = d; fp_ch_en[ch] = en;
    end else begin
      rr_ch_wr[ch] = wr; rr_ch_addr[ch*AW +: AW] = a; rr_ch_wdata[ch*DW +: DW] = d; rr_ch_en[ch] = en;
    end
  endtask

  task automatic push_exp(input bit fp, input int ch, input bit wr, input logic [AW-1:0] a);
    logic [N-1:0]  oh;
    logic [DW-1:0] d;
    oh = N'(1) << ch;
    if (fp) begin
      d = wr ? fp_last : mem_model(a);
      if (!wr) fp_last = d;
      fp_exp_q.push_back({oh, d});
    end else begin
      d = wr ? rr_last : mem_model(a);
      if (!wr) rr_last = d;
      rr_exp_q.push_back({oh, d});
    end
  endtask

  task automatic wait_empty(input bit fp, input string tag);
    int sz;
    for (int i = 0; i < 300; i++) begin
      step();
      sz = fp ? fp_exp_q.size() : rr_exp_q.size();
      if (sz == 0) return;
    end
    sz = fp ? fp_exp_q.size() : rr_exp_q.size();
    chk(tag, 64'(sz), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    rr_last = '0;
    fp_last = '0;
  endtask

  task automatic measure_en(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit wr, output int cycles, output int first);
    cycles = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rr_mem_en) begin
        if (first < 0) first = i;
        cycles++;
        chk({tag, "_addr"}, 64'(rr_mem_addr), 64'(a));
        chk({tag, "_wdata"}, 64'(rr_mem_wdata), 64'(d));
        chk({tag, "_wr"}, 64'(rr_mem_wr), 64'(wr));
      end else if (cycles > 0) begin
        return;
      end
    end
    chk({tag, "_en_end"}, 64'(rr_mem_en), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int first;
    logic [DW-1:0] held;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_mem_en", 64'(rr_mem_en), 64'd0);
    chk("rst_mem_wr", 64'(rr_mem_wr), 64'd0);
    chk("rst_mem_addr", 64'(rr_mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(rr_mem_wdata), 64'd0);
    chk("rst_ch_rdy", 64'(rr_ch_rdy), 64'd0);
    chk("rst_ch_rdata", 64'(rr_ch_rdata), 64'd0);
    chk("rst_state", 64'(rr_dbg_state), 64'd0);
    chk("rst_fp_mem_en", 64'(fp_mem_en), 64'd0);
    reset = 1'b0;

    // Single read, memory answers in the first BUSY cycle
    rr_stall = 0;
    push_exp(0, 0, 1'b0, 32'h100);
    set_ch(0, 0, 1'b0, 32'h100, 32'h0, 1'b1);
    measure_en("read", 32'h100, 32'h0, 1'b0, cyc, first);
    set_ch(0, 0, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("read_latency", 64'(first), 64'd0);
    chk("read_en_cycles", 64'(cyc), 64'd1);
    wait_empty(0, "read_done");

    // Write with a stalled memory: mem_en held 4 cycles, ch_rdata unchanged
    rr_stall = 3;
    push_exp(0, 1, 1'b1, 32'h2000);
    set_ch(0, 1, 1'b1, 32'h2000, 32'h1234_5678, 1'b1);
    measure_en("write", 32'h2000, 32'h1234_5678, 1'b1, cyc, first);
    set_ch(0, 1, 1'b1, 32'h2000, 32'h1234_5678, 1'b0);
    chk("write_en_cycles", 64'(cyc), 64'd4);
    wait_empty(0, "write_done");

    // Round-robin contention with every channel requesting continuously
    do_reset();
    rr_stall = 1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < N; c++) begin
        push_exp(0, c, c[0], 32'h1000 + 32'(c) * 32'h40);
      end
    end
    for (int c = 0; c < N; c++) begin
      set_ch(0, c, c[0], 32'h1000 + 32'(c) * 32'h40, 32'hA000_0000 + 32'(c), 1'b1);
    end
    wait_empty(0, "rr_contention_done");
    rr_ch_en = '0;
    step();
    chk("rr_quiet_after_drop", 64'(rr_mem_en), 64'd0);

    // Move the round-robin pointer to channel 1 before the mid-BUSY reset
    rr_stall = 0;
    push_exp(0, 1, 1'b0, 32'h1500);
    set_ch(0, 1, 1'b0, 32'h1500, 32'h0, 1'b1);
    wait_empty(0, "ptr_move_done");
    set_ch(0, 1, 1'b0, 32'h1500, 32'h0, 1'b0);

    // Reset while a transaction is in flight
    rr_resp_on = 1'b0;
    rr_mem_rdy = 1'b0;
    set_ch(0, 3, 1'b0, 32'h3000, 32'h0, 1'b1);
    step();
    chk("abort_busy_en", 64'(rr_mem_en), 64'd1);
    step();
    reset = 1'b1;
    step();
    chk("abort_mem_en", 64'(rr_mem_en), 64'd0);
    chk("abort_ch_rdy", 64'(rr_ch_rdy), 64'd0);
    chk("abort_state", 64'(rr_dbg_state), 64'd0);
    chk("abort_mem_addr", 64'(rr_mem_addr), 64'd0);
    chk("abort_ch_rdata", 64'(rr_ch_rdata), 64'd0);
    reset = 1'b0;
    rr_last = '0;
    set_ch(0, 3, 1'b0, 32'h3000, 32'h0, 1'b0);
    rr_mem_rdata = 32'hFEED_F00D;
    rr_mem_rdy = 1'b1;
    step();
    rr_mem_rdy = 1'b0;
    chk("late_rdy_ch_rdy", 64'(rr_ch_rdy), 64'd0);
    chk("late_rdy_state", 64'(rr_dbg_state), 64'd0);
    chk("late_rdy_rdata", 64'(rr_ch_rdata), 64'd0);
    step();
    chk("late_rdy_ch_rdy2", 64'(rr_ch_rdy), 64'd0);
    rr_resp_on = 1'b1;

    // First arbitration after reset: channel 0 beats channel 2
    push_exp(0, 0, 1'b0, 32'h4000);
    set_ch(0, 0, 1'b0, 32'h4000, 32'h0, 1'b1);
    set_ch(0, 2, 1'b0, 32'h4200, 32'h0, 1'b1);
    wait_empty(0, "post_reset_ch0");
    push_exp(0, 2, 1'b0, 32'h4200);
    set_ch(0, 0, 1'b0, 32'h4000, 32'h0, 1'b0);
    wait_empty(0, "post_reset_ch2");
    set_ch(0, 2, 1'b0, 32'h4200, 32'h0, 1'b0);
    step();

    // Spurious mem_rdy while idle
    rr_resp_on = 1'b0;
    held = rr_last;
    rr_mem_rdata = 32'hBAD0_BAD0;
    rr_mem_rdy = 1'b1;
    step();
    rr_mem_rdy = 1'b0;
    chk("spur_state", 64'(rr_dbg_state), 64'd0);
    chk("spur_ch_rdy", 64'(rr_ch_rdy), 64'd0);
    chk("spur_mem_en", 64'(rr_mem_en), 64'd0);
    chk("spur_rdata", 64'(rr_ch_rdata), 64'(held));
    step();
    chk("spur_rdata2", 64'(rr_ch_rdata), 64'(held));
    rr_resp_on = 1'b1;

    // Fixed priority: ch0 keeps winning while held, ch2 only once ch0 drops
    for (int r = 0; r < 3; r++) push_exp(1, 0, 1'b0, 32'h5000);
    set_ch(1, 0, 1'b0, 32'h5000, 32'h0, 1'b1);
    set_ch(1, 2, 1'b1, 32'h5200, 32'h5555_AAAA, 1'b1);
    wait_empty(1, "fp_ch0_done");
    push_exp(1, 2, 1'b1, 32'h5200);
    set_ch(1, 0, 1'b0, 32'h5000, 32'h0, 1'b0);
    wait_empty(1, "fp_ch2_done");
    set_ch(1, 2, 1'b1, 32'h5200, 32'h5555_AAAA, 1'b0);
    step();
    step();
    chk("fp_quiet", 64'(fp_mem_en), 64'd0);

    chk("rr_queue_drained", 64'(rr_exp_q.size()), 64'd0);
    chk("fp_queue_drained", 64'(fp_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
